// File: rtl/seq_serializer.sv
// seq_serializer: parallel-in / serial-out stage that feeds a bit-serial
// consumer (the sequence detector's x input), one bit per clock.
//
// Ports:
//   clk, rst     - clock; asynchronous active-high reset
//   din          - WIDTH-bit word to serialize
//   din_valid    - din holds a word to transfer
//   din_ready    - one-word holding buffer can take a word
//   x_out        - serial bit (IDLE_BIT when no word is being shifted)
//   x_valid      - x_out carries a data bit
//   frame_start  - x_out carries the first bit of a word
//   busy         - shifter active or holding buffer occupied
//
// A word waits in `hold` until the shifter is idle or presenting the last bit
// of the current word, so a continuous source yields a gapless stream.
module seq_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             frame_start,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_nx;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             load;

  assign din_ready = !hold_full && !rst;
  assign busy      = (state == SHIFT) || hold_full;
  assign accept    = din_valid && din_ready;
  // cnt==0 in SHIFT means the last bit is on x_out: reload without a gap.
  assign load      = hold_full && ((state == IDLE) || (cnt == '0));
  assign sh_nx     = MSB_FIRST ? (sh << 1) : (sh >> 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      hold        <= '0;
      hold_full   <= 1'b0;
      sh          <= '0;
      cnt         <= '0;
      x_out       <= IDLE_BIT;
      x_valid     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      if (load) begin
        sh          <= hold;
        cnt         <= CW'(WIDTH - 1);
        x_out       <= MSB_FIRST ? hold[WIDTH-1] : hold[0];
        x_valid     <= 1'b1;
        frame_start <= 1'b1;
        state       <= SHIFT;
      end else if (state == SHIFT && cnt != '0) begin
        sh          <= sh_nx;
        x_out       <= MSB_FIRST ? sh_nx[WIDTH-1] : sh_nx[0];
        cnt         <= cnt - 1'b1;
        frame_start <= 1'b0;
      end else if (state == SHIFT) begin
        state       <= IDLE;
        x_out       <= IDLE_BIT;
        x_valid     <= 1'b0;
        frame_start <= 1'b0;
      end

      // accept and load are exclusive (ready needs an empty buffer, load a
      // full one), but accept is given priority so hold_full stays set if
      // both ever coincide.
      if (accept) begin
        hold      <= din;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_seq_serializer.sv
module tb_seq_serializer;
  logic       clk, rst;
  logic [7:0] din;
  logic       din_valid;
  logic       rdy_a, xa, va, fsa, busy_a;
  logic       rdy_b, xb, vb, fsb, busy_b;

  int n_cmp = 0;
  int n_bad = 0;

  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_a (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(rdy_a), .x_out(xa), .x_valid(va), .frame_start(fsa), .busy(busy_a));

  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_b (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(rdy_b), .x_out(xb), .x_valid(vb), .frame_start(fsb), .busy(busy_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // pend: words accepted but not yet started (at most one).
  // qa/qb: bits of the current word still to come, MSB-first / LSB-first.
  logic [7:0] pend[$];
  bit         qa[$], qb[$];
  logic [7:0] loaded[$];
  logic       ea_x = 0, eb_x = 0, e_v = 0, e_fs = 0;
  int         cyc = 0, run = 0, maxrun = 0;
  int         fs_log[$];
  logic       r_s, v_s, acc;
  logic [7:0] d_s, w;

  initial begin
    forever begin
      @(posedge clk);
      r_s = rst; v_s = din_valid; d_s = din;
      #1;
      cyc++;
      if (r_s) begin
        pend.delete(); qa.delete(); qb.delete();
        ea_x = 0; eb_x = 0; e_v = 0; e_fs = 0;
      end else begin
        acc = v_s && (pend.size() == 0);
        if (pend.size() > 0 && qa.size() == 0) begin
          w = pend.pop_front();
          loaded.push_back(w);
          for (int i = 0; i < 8; i++) begin
            qa.push_back(w[7-i]);
            qb.push_back(w[i]);
          end
          ea_x = qa.pop_front(); eb_x = qb.pop_front();
          e_v = 1; e_fs = 1;
        end else if (qa.size() > 0) begin
          ea_x = qa.pop_front(); eb_x = qb.pop_front();
          e_fs = 0;
        end else begin
          ea_x = 0; eb_x = 0; e_v = 0; e_fs = 0;
        end
        if (acc) pend.push_back(d_s);
      end
      chk("x_msb", xa, ea_x);
      chk("x_lsb", xb, eb_x);
      chk("vld_a", va, e_v);
      chk("vld_b", vb, e_v);
      chk("fs_a", fsa, e_fs);
      chk("fs_b", fsb, e_fs);
      chk("rdy_a", rdy_a, (pend.size() == 0) && !rst);
      chk("rdy_b", rdy_b, (pend.size() == 0) && !rst);
      chk("busy_a", busy_a, e_v || (pend.size() > 0));
      chk("busy_b", busy_b, e_v || (pend.size() > 0));
      if (fsa) fs_log.push_back(cyc);
      if (va) run++; else run = 0;
      if (run > maxrun) maxrun = run;
    end
  end

  // ---------------- stimulus ----------------
  bit saw_notready;

  task automatic offer(input logic [7:0] word);
    logic rdy_now;
    int   n;
    @(negedge clk);
    din = word; din_valid = 1;
    n = 0;
    do begin
      rdy_now = rdy_a;
      if (!rdy_now) saw_notready = 1;
      @(posedge clk); @(negedge clk);
      n++;
    end while (!rdy_now && n < 40);
    if (!rdy_now) chk("offer_timeout", 0, 1);
    din_valid = 0;
  endtask

  task automatic single(input logic [7:0] word, input logic [7:0] seq_a, input logic [7:0] seq_b);
    @(negedge clk);
    chk("lit_rdy", rdy_a, 1);
    din = word; din_valid = 1;
    @(posedge clk);
    @(negedge clk) din_valid = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("lit_xa", xa, seq_a[7-i]);
      chk("lit_xb", xb, seq_b[7-i]);
      chk("lit_fs", fsa, i == 0);
    end
    @(posedge clk); #1;
    chk("lit_vld_end", va, 0);
    chk("lit_x_idle", xa, 0);
  endtask

  initial begin
    int cnt_v;
    rst = 1; din = 8'hFF; din_valid = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", rdy_a, 0);
    chk("rst_x", xa, 0);
    chk("rst_vld", va, 0);
    chk("rst_busy", busy_a, 0);
    rst = 0; din_valid = 0;
    repeat (2) @(posedge clk);

    // single word MSB-first (also LSB-first on the second instance)
    single(8'b1101_1010, 8'b1101_1010, 8'b0101_1011);
    // LSB-first ordering of 0000_1011
    single(8'b0000_1011, 8'b0000_1011, 8'b1101_0000);

    // back-to-back words: gapless, frame starts 8 apart
    fs_log.delete(); maxrun = 0;
    offer(8'hA5); offer(8'h3C);
    repeat (20) @(posedge clk);
    chk("b2b_frames", fs_log.size(), 2);
    if (fs_log.size() == 2) chk("b2b_spacing", fs_log[1] - fs_log[0], 8);
    chk("b2b_run", maxrun, 16);

    // backpressure: three words in order, none lost
    loaded.delete(); saw_notready = 0;
    offer(8'h11); offer(8'h22); offer(8'h33);
    repeat (30) @(posedge clk);
    chk("bp_count", loaded.size(), 3);
    if (loaded.size() == 3) begin
      chk("bp_w0", loaded[0], 8'h11);
      chk("bp_w1", loaded[1], 8'h22);
      chk("bp_w2", loaded[2], 8'h33);
    end
    chk("bp_notready", saw_notready, 1);

    // async reset mid-word with a second word held
    offer(8'hF0);
    din = 8'h0F; din_valid = 1;
    for (int i = 0; i < 20 && !fsa; i++) begin @(posedge clk); #1; end
    chk("mid_started", fsa, 1);
    repeat (3) @(posedge clk);
    #1; din_valid = 0;
    chk("mid_held", busy_a && !rdy_a, 1);
    #3 rst = 1;
    #1;
    chk("arst_x", xa, 0);
    chk("arst_vld", va, 0);
    chk("arst_fs", fsa, 0);
    chk("arst_rdy", rdy_a, 0);
    chk("arst_busy", busy_a, 0);
    @(posedge clk);
    @(negedge clk) rst = 0;
    cnt_v = 0;
    for (int i = 0; i < 12; i++) begin @(posedge clk); #1; if (va) cnt_v++; end
    chk("arst_no_resume", cnt_v, 0);
    offer(8'h5A);
    repeat (12) @(posedge clk);

    // randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      din = 8'($urandom);
      din_valid = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
    end
    @(negedge clk);
    rst = 0; din_valid = 0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
